// File: rtl/uart_rx_deserializer_if.sv
// UART RX deserializer bus: voted-bit strobes and frame start in,
// assembled word, result pulses and frame-phase levels out.
//   master : sampler/controller side (drives bits, reads results)
//   slave  : deserializer side
interface uart_rx_deserializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  sampled_data;
    logic                  bit_valid;
    logic                  frame_start;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  parity_error;
    logic                  stop_error;
    logic                  data_transmitted_finished_flag;
    logic                  busy;

    modport master (
        output sampled_data,
        output bit_valid,
        output frame_start,
        input  data_out,
        input  data_valid,
        input  parity_error,
        input  stop_error,
        input  data_transmitted_finished_flag,
        input  busy
    );

    modport slave (
        input  sampled_data,
        input  bit_valid,
        input  frame_start,
        output data_out,
        output data_valid,
        output parity_error,
        output stop_error,
        output data_transmitted_finished_flag,
        output busy
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART RX deserializer: assembles LSB-first data bits, checks parity/stop.
// Ports: clk, rst (async high), bus (slave) carrying strobes and results.
module uart_rx_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input logic                  clk,
    input logic                  rst,
    uart_rx_deserializer_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  pbad_q, pbad_d;
    logic                  dv_q, dv_d;
    logic                  pe_q, pe_d;
    logic                  se_q, se_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            dout_q  <= '0;
            pbad_q  <= 1'b0;
            dv_q    <= 1'b0;
            pe_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            dout_q  <= dout_d;
            pbad_q  <= pbad_d;
            dv_q    <= dv_d;
            pe_q    <= pe_d;
            se_q    <= se_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        dout_d  = dout_q;
        pbad_d  = pbad_q;
        dv_d    = 1'b0;
        pe_d    = 1'b0;
        se_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // frame_start has priority; a coincident strobe is dropped
                if (bus.frame_start) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    sh_d    = '0;
                    pbad_d  = 1'b0;
                end
            end
            DATA: begin
                if (bus.bit_valid) begin
                    // shift right, new bit at MSB: first bit ends at [0]
                    sh_d = (sh_q >> 1)
                         | (DATA_WIDTH'(bus.sampled_data) << (DATA_WIDTH - 1));
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(DATA_WIDTH - 1))
                        state_d = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bus.bit_valid) begin
                    // bad when bit differs from XOR(data) ^ PARITY_ODD
                    pbad_d  = bus.sampled_data ^ (^sh_q) ^ PARITY_ODD;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bus.bit_valid) begin
                    state_d = IDLE;
                    pe_d    = pbad_q;
                    se_d    = ~bus.sampled_data;
                    if (!pbad_q && bus.sampled_data) begin
                        dv_d   = 1'b1;
                        dout_d = sh_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.data_out     = dout_q;
    assign bus.data_valid   = dv_q;
    assign bus.parity_error = pe_q;
    assign bus.stop_error   = se_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.data_transmitted_finished_flag =
        (state_q == PARITY) || (state_q == STOP);
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer: parity and no-parity DUTs.
// Stimulus pushes expected frame results; monitors pop on each pulse.
module tb_uart_rx_deserializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_deserializer_if #(.DATA_WIDTH(8)) ia ();
    uart_rx_deserializer_if #(.DATA_WIDTH(8)) ib ();

    uart_rx_deserializer #(
        .DATA_WIDTH(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(ia.slave)
    );

    uart_rx_deserializer #(
        .DATA_WIDTH(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(ib.slave)
    );

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic       pe;
        logic       se;
        int         c;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", n, act, exp);
    endtask

    task automatic mon(input string t, input exp_t e, input logic [7:0] d,
                       input logic v, input logic pe, input logic se);
        chk({t, "_data_out"}, 32'(d), 32'(e.d));
        chk({t, "_data_valid"}, 32'(v), 32'(e.v));
        chk({t, "_parity_error"}, 32'(pe), 32'(e.pe));
        chk({t, "_stop_error"}, 32'(se), 32'(e.se));
        chk({t, "_latency_cycle"}, 32'(cyc), 32'(e.c));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && (ia.data_valid || ia.parity_error || ia.stop_error)) begin
            if (qa.size() == 0) begin
                total++;
                $display("FAIL a_unexpected_pulse: got v=%0b pe=%0b se=%0b expected none",
                         ia.data_valid, ia.parity_error, ia.stop_error);
            end else begin
                e = qa.pop_front();
                mon("a", e, ia.data_out, ia.data_valid,
                    ia.parity_error, ia.stop_error);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && (ib.data_valid || ib.parity_error || ib.stop_error)) begin
            if (qb.size() == 0) begin
                total++;
                $display("FAIL b_unexpected_pulse: got v=%0b pe=%0b se=%0b expected none",
                         ib.data_valid, ib.parity_error, ib.stop_error);
            end else begin
                e = qb.pop_front();
                mon("b", e, ib.data_out, ib.data_valid,
                    ib.parity_error, ib.stop_error);
            end
        end
    end

    task automatic drive(input bit w, input bit fs, input bit bv,
                         input bit sd);
        if (!w) begin
            ia.frame_start = fs; ia.bit_valid = bv; ia.sampled_data = sd;
        end else begin
            ib.frame_start = fs; ib.bit_valid = bv; ib.sampled_data = sd;
        end
    endtask

    task automatic step(input bit w, input bit fs, input bit bv,
                        input bit sd);
        drive(w, fs, bv, sd);
        @(posedge clk); #1;
        drive(w, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic strobe(input bit w, input bit b);
        step(w, 1'b0, 1'b1, b);
        @(posedge clk); #1;
    endtask

    task automatic send_data(input bit w, input logic [7:0] d);
        step(w, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) strobe(w, d[i]);
    endtask

    // stop strobe; result pulse must be visible in the very next cycle
    task automatic send_stop(input bit w, input bit b, input logic [7:0] ed,
                             input bit ev, input bit epe, input bit ese);
        exp_t e;
        drive(w, 1'b0, 1'b1, b);
        @(posedge clk); #1;
        e.d = ed; e.v = ev; e.pe = epe; e.se = ese; e.c = cyc;
        if (!w) qa.push_back(e);
        else qb.push_back(e);
        drive(w, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data_out", 32'(ia.data_out), 32'h0);
        chk("rst_busy", 32'(ia.busy), 32'h0);
        chk("rst_flag", 32'(ia.data_transmitted_finished_flag), 32'h0);
        chk("rst_pulses",
            32'({ia.data_valid, ia.parity_error, ia.stop_error}), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: good 0xA5, even parity 0
        send_data(1'b0, 8'hA5);
        chk("t1_flag_parity", 32'(ia.data_transmitted_finished_flag), 32'h1);
        strobe(1'b0, 1'b0);
        send_stop(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        chk("t1_busy_after", 32'(ia.busy), 32'h0);
        chk("t1_data_hold", 32'(ia.data_out), 32'hA5);

        // 2: parity wrong after reset, data_out stays 0
        do_reset();
        send_data(1'b0, 8'hA5);
        strobe(1'b0, 1'b1);
        send_stop(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);

        // 3: 0x3C stop=0, then bad parity and stop=0
        send_data(1'b0, 8'h3C);
        strobe(1'b0, 1'b0);
        send_stop(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        send_data(1'b0, 8'h3C);
        strobe(1'b0, 1'b1);
        send_stop(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // 4: no parity, 0xFF; flag tracks PARITY/STOP only
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) strobe(1'b1, 1'b1);
        chk("t4_flag_before", 32'(ib.data_transmitted_finished_flag), 32'h0);
        chk("t4_busy_mid", 32'(ib.busy), 32'h1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("t4_flag_after8", 32'(ib.data_transmitted_finished_flag), 32'h1);
        @(posedge clk); #1;
        send_stop(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        chk("t4_flag_idle", 32'(ib.data_transmitted_finished_flag), 32'h0);
        chk("t4_busy_idle", 32'(ib.busy), 32'h0);

        // 5: reset mid-frame, then good 0x81
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) strobe(1'b0, 1'b1);
        rst = 1'b1;
        #3;
        chk("t5_rst_busy", 32'(ia.busy), 32'h0);
        chk("t5_rst_data", 32'(ia.data_out), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_data(1'b0, 8'h81);
        strobe(1'b0, 1'b0);
        send_stop(1'b0, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0);

        // 6: idle strobe ignored; coincident start+bit drops the bit
        strobe(1'b0, 1'b1);
        chk("t6_idle_busy", 32'(ia.busy), 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk("t6_started", 32'(ia.busy), 32'h1);
        for (int i = 0; i < 8; i++) strobe(1'b0, 1'(8'h5A >> i));
        strobe(1'b0, 1'b0);
        send_stop(1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("a_queue_drained", 32'(qa.size()), 32'h0);
        chk("b_queue_drained", 32'(qb.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- Downstream stage of the UART RX majority-vote sampler.
- Consumes one voted bit per strobe and assembles DATA_WIDTH data bits, LSB first.
- Checks the optional parity bit and the stop bit, then presents the received byte with a one-cycle valid pulse and error flags to the RX controller and the user side.
- Owns its own frame-phase state machine, so the controller only signals start-bit acceptance.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (1..16)
PARITY_EN, 1, 1 = a parity bit follows the data bits; 0 = no parity bit
PARITY_ODD, 0, 0 = even parity expected; 1 = odd parity expected

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
sampled_data  input  1  majority-voted bit value from the sampler
bit_valid  input  1  one-cycle strobe: sampled_data holds a final voted bit
frame_start  input  1  one-cycle strobe: start bit validated, frame begins
data_out  output  DATA_WIDTH  last received data word
data_valid  output  1  one-cycle pulse: data_out updated, frame good
parity_error  output  1  one-cycle pulse: parity mismatch on completed frame
stop_error  output  1  one-cycle pulse: stop bit sampled as 0
data_transmitted_finished_flag  output  1  level: all data bits received, now in PARITY or STOP
busy  output  1  level: state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE; shift register, bit counter, data_out = 0; all pulses 0; busy=0; finished flag=0. Reset mid-frame discards the partial frame with no pulses.
- States: IDLE, DATA, PARITY, STOP.
- IDLE:
  - frame_start=1 -> DATA; bit counter cleared; shift register cleared.
  - bit_valid is ignored.
  - If frame_start and bit_valid arrive in the same cycle, frame_start wins and bit_valid is dropped.
- DATA:
  - Each bit_valid shifts sampled_data in at the MSB end (shift right), so the first bit lands at data_out[0] after completion.
  - The counter increments on each bit_valid.
  - On the DATA_WIDTH-th strobe: go to PARITY if PARITY_EN, else STOP.
  - Counter width is clog2(DATA_WIDTH+1) bits; no wrap is permitted within a frame.
- PARITY: the next bit_valid captures the parity bit -> STOP. Expected parity = XOR of data bits, XORed with PARITY_ODD; the parity bit must equal it.
- STOP: the next bit_valid is the stop bit. Go to IDLE on the following edge, and in that same edge drive the frame-result outputs:
  - Parity OK (or PARITY_EN=0) and stop=1: data_out <= assembled word; data_valid=1.
  - Parity mismatch: parity_error=1; data_out not updated; data_valid=0.
  - Stop=0: stop_error=1; data_out not updated; data_valid=0.
  - Both errors fire together if both apply.
- Latency: pulses appear exactly 1 clk after the stop-bit bit_valid cycle and last exactly 1 cycle.
- frame_start while not IDLE is ignored; the controller guarantees this does not happen.
- data_transmitted_finished_flag is combinational from state: 1 in PARITY and STOP, 0 elsewhere.
- busy is 1 in DATA, PARITY and STOP.
- bit_valid held high for multiple cycles counts once per cycle. The sampler guarantees single-cycle strobes; the block does not edge-detect.
- data_out holds its value until the next good frame or reset.

Test Plan:
1. Reset, then frame_start, bits of 0xA5 LSB first (1,0,1,0,0,1,0,1), parity 0 (even), stop 1 -> data_out=0xA5, data_valid high for exactly 1 cycle after the stop strobe, no errors, busy back to 0.
2. Same frame with parity bit 1 -> parity_error pulses once, data_valid=0, data_out keeps its previous value (0x00 after reset).
3. Frame 0x3C with correct parity, stop bit 0 -> stop_error pulses, data_valid=0. Repeat with a bad parity bit as well -> both errors pulse in the same cycle.
4. PARITY_EN=0, frame 0xFF, stop 1 -> data_valid after exactly 9 bit_valid strobes. data_transmitted_finished_flag rises the cycle after the 8th strobe and falls on return to IDLE.
5. Assert rst after 4 data bits, release, then send full frame 0x81 -> first frame produces no pulses; second yields data_out=0x81 with data_valid.
6. In IDLE, drive frame_start and bit_valid in the same cycle, then 8 data bits + parity + stop for 0x5A -> the simultaneous bit is dropped and data_out=0x5A. Also drive bit_valid with no frame_start in IDLE -> no state change.
